// File: rtl/mig7_memtest_pkg.sv
// Shared types and constants for the MIG7 memory tester: FSM states,
// MIG command codes and the 32-bit Galois LFSR step.
package mig7_memtest_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_CAL = 3'd1,
      ST_WRITE    = 3'd2,
      ST_READ     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   localparam logic [2:0]  CMD_WR    = 3'b000;
   localparam logic [2:0]  CMD_RD    = 3'b001;

   // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/mig7_memtest_lfsr.sv
// 32-bit pattern LFSR with load and advance; load wins over advance.
module mig7_memtest_lfsr
   import mig7_memtest_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] load_val,
   output logic [31:0] state
);

   logic [31:0] state_d, state_q;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = load_val;
      end else if (advance) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/mig7_memtest.sv
// Write-then-read-back pattern tester driving a MIG7 user interface.
// state    | meaning
// IDLE     | after reset, waiting for start
// WAIT_CAL | run accepted, waiting for init_calib_complete
// WRITE    | issuing write commands and data beats independently
// READ     | issuing read commands, checking returned beats in order
// DONE     | run finished or aborted; pass/err_cnt valid
module mig7_memtest
   import mig7_memtest_pkg::*;
#(
   parameter int WORDS     = 1024,
   parameter int ADDR_STEP = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [31:0]  seed,
   input  logic [27:0]  base_addr,
   output logic [27:0]  app_addr,
   output logic [2:0]   app_cmd,
   output logic         app_en,
   output logic [127:0] app_wdf_data,
   output logic         app_wdf_end,
   output logic [15:0]  app_wdf_mask,
   output logic         app_wdf_wren,
   input  logic [127:0] app_rd_data,
   input  logic         app_rd_data_end,
   input  logic         app_rd_data_valid,
   input  logic         app_rdy,
   input  logic         app_wdf_rdy,
   output logic         app_sr_req,
   output logic         app_ref_req,
   output logic         app_zq_req,
   input  logic         app_sr_active,
   input  logic         app_ref_ack,
   input  logic         app_zq_ack,
   input  logic         init_calib_complete,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [15:0]  err_cnt,
   output logic [27:0]  first_err_addr
);

   localparam logic [15:0] WORDS_C = 16'(WORDS);
   localparam logic [27:0] STEP_C  = 28'(ADDR_STEP);

   state_t      state_d, state_q;
   logic [27:0] app_addr_d, app_addr_q;
   logic [2:0]  app_cmd_d, app_cmd_q;
   logic        app_en_d, app_en_q;
   logic        wren_d, wren_q;
   logic [27:0] base_d, base_q;
   logic [27:0] rd_addr_d, rd_addr_q;
   logic [15:0] cmd_left_d, cmd_left_q;
   logic [15:0] dat_left_d, dat_left_q;
   logic [15:0] rd_left_d, rd_left_q;
   logic [15:0] err_cnt_d, err_cnt_q;
   logic [27:0] first_err_d, first_err_q;
   logic        aborted_d, aborted_q;

   logic        gen_load, gen_adv, chk_load, chk_adv;
   logic [31:0] lfsr_seed, gen_word, chk_word;

   logic unused_ok;
   assign unused_ok = ^{app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};

   assign lfsr_seed = (seed == 32'h0) ? 32'h0000_0001 : seed;

   mig7_memtest_lfsr u_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (gen_load),
      .advance  (gen_adv),
      .load_val (lfsr_seed),
      .state    (gen_word)
   );

   mig7_memtest_lfsr u_chk (
      .clk      (clk),
      .rst      (rst),
      .load     (chk_load),
      .advance  (chk_adv),
      .load_val (lfsr_seed),
      .state    (chk_word)
   );

   always_comb begin
      state_d     = state_q;
      app_addr_d  = app_addr_q;
      app_cmd_d   = app_cmd_q;
      app_en_d    = app_en_q;
      wren_d      = wren_q;
      base_d      = base_q;
      rd_addr_d   = rd_addr_q;
      cmd_left_d  = cmd_left_q;
      dat_left_d  = dat_left_q;
      rd_left_d   = rd_left_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      aborted_d   = aborted_q;
      gen_load    = 1'b0;
      gen_adv     = 1'b0;
      chk_load    = 1'b0;
      chk_adv     = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_WAIT_CAL;
               base_d      = base_addr;
               app_addr_d  = base_addr;
               rd_addr_d   = base_addr;
               cmd_left_d  = WORDS_C;
               dat_left_d  = WORDS_C;
               rd_left_d   = WORDS_C;
               err_cnt_d   = '0;
               first_err_d = '0;
               aborted_d   = 1'b0;
               gen_load    = 1'b1;
               chk_load    = 1'b1;
            end
         end
         ST_WAIT_CAL: begin
            if (init_calib_complete) begin
               state_d   = ST_WRITE;
               app_cmd_d = CMD_WR;
               app_en_d  = 1'b1;
               wren_d    = 1'b1;
            end
         end
         ST_WRITE: begin
            if (!init_calib_complete) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
               app_en_d  = 1'b0;
               wren_d    = 1'b0;
            end else if (cmd_left_q == 16'd0 && dat_left_q == 16'd0) begin
               state_d    = ST_READ;
               app_cmd_d  = CMD_RD;
               app_en_d   = 1'b1;
               app_addr_d = base_q;
               cmd_left_d = WORDS_C;
            end else begin
               // command and data channels retire independently
               if (app_en_q && app_rdy) begin
                  cmd_left_d = cmd_left_q - 16'd1;
                  app_addr_d = app_addr_q + STEP_C;
                  if (cmd_left_q == 16'd1) app_en_d = 1'b0;
               end
               if (wren_q && app_wdf_rdy) begin
                  dat_left_d = dat_left_q - 16'd1;
                  gen_adv    = 1'b1;
                  if (dat_left_q == 16'd1) wren_d = 1'b0;
               end
            end
         end
         ST_READ: begin
            if (!init_calib_complete) begin
               state_d   = ST_DONE;
               aborted_d = 1'b1;
               app_en_d  = 1'b0;
            end else begin
               if (app_en_q && app_rdy) begin
                  cmd_left_d = cmd_left_q - 16'd1;
                  app_addr_d = app_addr_q + STEP_C;
                  if (cmd_left_q == 16'd1) app_en_d = 1'b0;
               end
               if (app_rd_data_valid) begin
                  chk_adv   = 1'b1;
                  rd_left_d = rd_left_q - 16'd1;
                  rd_addr_d = rd_addr_q + STEP_C;
                  if (app_rd_data != {4{chk_word}}) begin
                     if (err_cnt_q == 16'd0) first_err_d = rd_addr_q;
                     if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                  end
                  if (rd_left_q == 16'd1) begin
                     state_d  = ST_DONE;
                     app_en_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         app_addr_q  <= '0;
         app_cmd_q   <= '0;
         app_en_q    <= 1'b0;
         wren_q      <= 1'b0;
         base_q      <= '0;
         rd_addr_q   <= '0;
         cmd_left_q  <= '0;
         dat_left_q  <= '0;
         rd_left_q   <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         app_addr_q  <= app_addr_d;
         app_cmd_q   <= app_cmd_d;
         app_en_q    <= app_en_d;
         wren_q      <= wren_d;
         base_q      <= base_d;
         rd_addr_q   <= rd_addr_d;
         cmd_left_q  <= cmd_left_d;
         dat_left_q  <= dat_left_d;
         rd_left_q   <= rd_left_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         aborted_q   <= aborted_d;
      end
   end

   assign app_addr       = app_addr_q;
   assign app_cmd        = app_cmd_q;
   assign app_en         = app_en_q;
   assign app_wdf_data   = {4{gen_word}};
   assign app_wdf_wren   = wren_q;
   assign app_wdf_end    = wren_q;
   assign app_wdf_mask   = '0;
   assign app_sr_req     = 1'b0;
   assign app_ref_req    = 1'b0;
   assign app_zq_req     = 1'b0;
   assign busy           = (state_q == ST_WAIT_CAL) || (state_q == ST_WRITE) || (state_q == ST_READ);
   assign done           = (state_q == ST_DONE);
   assign pass           = done && (err_cnt_q == 16'd0) && !aborted_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_mig7_memtest.sv
// Bench for mig7_memtest: behavioural MIG model with random ready throttling,
// a 10-cycle read pipe and an optional single-bit read corruption.
module tb_mig7_memtest;
   import mig7_memtest_pkg::*;

   localparam int W    = 16;
   localparam int STEP = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  seed;
   logic [27:0]  base_addr;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic [127:0] app_wdf_data;
   logic         app_wdf_end;
   logic [15:0]  app_wdf_mask;
   logic         app_wdf_wren;
   logic [127:0] app_rd_data = '0;
   logic         app_rd_data_end = 1'b0;
   logic         app_rd_data_valid = 1'b0;
   logic         app_rdy = 1'b0;
   logic         app_wdf_rdy = 1'b0;
   logic         app_sr_req, app_ref_req, app_zq_req;
   logic         init_calib_complete;
   logic         busy, done, pass;
   logic [15:0]  err_cnt;
   logic [27:0]  first_err_addr;

   always #5 clk = ~clk;

   mig7_memtest #(.WORDS(W), .ADDR_STEP(STEP)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .seed                (seed),
      .base_addr           (base_addr),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_rd_data         (app_rd_data),
      .app_rd_data_end     (app_rd_data_end),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rdy             (app_rdy),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_sr_req          (app_sr_req),
      .app_ref_req         (app_ref_req),
      .app_zq_req          (app_zq_req),
      .app_sr_active       (1'b0),
      .app_ref_ack         (1'b0),
      .app_zq_ack          (1'b0),
      .init_calib_complete (init_calib_complete),
      .busy                (busy),
      .done                (done),
      .pass                (pass),
      .err_cnt             (err_cnt),
      .first_err_addr      (first_err_addr)
   );

   typedef struct {
      logic [31:0] seed;
      logic [27:0] base;
      int          pct;
      int          corrupt;
      logic [15:0] exp_err;
      logic [27:0] exp_first;
      logic        exp_pass;
   } vec_t;

   typedef struct {
      int          due;
      logic [27:0] addr;
   } rd_req_t;

   int n_tests = 0;
   int n_fail  = 0;

   // expected run contents, written by the test, read by the MIG model
   logic [27:0]  exp_addr [W];
   logic [127:0] exp_data [W];
   int           pct = 100;
   bit           corrupt_on = 1'b0;
   logic [27:0]  corrupt_addr = '0;
   int           base_wc = 0, base_wb = 0, base_rc = 0;

   // MIG model bookkeeping, written only by the model
   int wr_cmd_n = 0, wr_beat_n = 0, rd_cmd_n = 0, rd_beat_n = 0;
   int addr_bad = 0, data_bad = 0;
   int cyc = 0;
   rd_req_t      rd_q [$];
   logic [27:0]  wq_addr [$];
   logic [127:0] wq_data [$];
   logic [127:0] mem [logic [27:0]];

   // snapshots taken by the test at the start of each run
   int s_rb, s_abad, s_dbad;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] galois_step(input logic [31:0] s);
      logic        fb;
      logic [31:0] r;
      fb = s[0];
      r  = s >> 1;
      if (fb) begin
         r[31] = ~r[31];
         r[21] = ~r[21];
         r[1]  = ~r[1];
         r[0]  = ~r[0];
      end
      return r;
   endfunction

   always @(negedge clk) begin : mig_model
      rd_req_t      r;
      logic [127:0] d;
      int           k;
      cyc++;
      app_rdy           = ($urandom_range(99) < pct);
      app_wdf_rdy       = ($urandom_range(99) < pct);
      app_rd_data_valid = 1'b0;
      app_rd_data_end   = 1'b0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
         r = rd_q.pop_front();
         d = mem.exists(r.addr) ? mem[r.addr] : '0;
         if (corrupt_on && r.addr == corrupt_addr) d[0] = ~d[0];
         app_rd_data       = d;
         app_rd_data_valid = 1'b1;
         app_rd_data_end   = 1'b1;
         rd_beat_n++;
      end
      if (app_en && app_rdy) begin
         if (app_cmd == CMD_WR) begin
            k = wr_cmd_n - base_wc;
            if (k < W && app_addr !== exp_addr[k]) addr_bad++;
            wq_addr.push_back(app_addr);
            wr_cmd_n++;
         end else begin
            k = rd_cmd_n - base_rc;
            if (app_cmd !== CMD_RD) addr_bad++;
            if (k < W && app_addr !== exp_addr[k]) addr_bad++;
            rd_q.push_back('{cyc + 10, app_addr});
            rd_cmd_n++;
         end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
         k = wr_beat_n - base_wb;
         if (k < W && app_wdf_data !== exp_data[k]) data_bad++;
         if (app_wdf_end !== 1'b1 || app_wdf_mask !== 16'h0) data_bad++;
         wq_data.push_back(app_wdf_data);
         wr_beat_n++;
      end
      while (wq_addr.size() > 0 && wq_data.size() > 0) begin
         mem[wq_addr.pop_front()] = wq_data.pop_front();
      end
   end

   task automatic prep(input vec_t v);
      logic [31:0] s;
      s = (v.seed == 32'h0) ? 32'h1 : v.seed;
      for (int i = 0; i < W; i++) begin
         exp_addr[i] = v.base + 28'(i * STEP);
         exp_data[i] = {4{s}};
         s = galois_step(s);
      end
      pct          = v.pct;
      corrupt_on   = (v.corrupt >= 0);
      corrupt_addr = v.base + 28'(v.corrupt * STEP);
      base_wc      = wr_cmd_n;
      base_wb      = wr_beat_n;
      base_rc      = rd_cmd_n;
      s_rb         = rd_beat_n;
      s_abad       = addr_bad;
      s_dbad       = data_bad;
   endtask

   task automatic pulse_start(input logic [31:0] sd, input logic [27:0] ba);
      @(negedge clk);
      seed      = sd;
      base_addr = ba;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic finish_run(input string tag, input vec_t v);
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, longint'(done), 1);
      check({tag, "_pass"}, longint'(pass), longint'(v.exp_pass));
      check({tag, "_err_cnt"}, longint'(err_cnt), longint'(v.exp_err));
      check({tag, "_first_err"}, longint'(first_err_addr), longint'(v.exp_first));
      check({tag, "_busy"}, longint'(busy), 0);
      repeat (20) @(negedge clk);
      check({tag, "_wr_cmds"}, longint'(wr_cmd_n - base_wc), W);
      check({tag, "_wr_beats"}, longint'(wr_beat_n - base_wb), W);
      check({tag, "_rd_cmds"}, longint'(rd_cmd_n - base_rc), W);
      check({tag, "_rd_beats"}, longint'(rd_beat_n - s_rb), W);
      check({tag, "_addr_errs"}, longint'(addr_bad - s_abad), 0);
      check({tag, "_data_errs"}, longint'(data_bad - s_dbad), 0);
      check({tag, "_app_en_after"}, longint'(app_en), 0);
      check({tag, "_done_held"}, longint'(done), 1);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      prep(v);
      pulse_start(v.seed, v.base);
      repeat (4) @(negedge clk);
      // a start while busy must not disturb the run
      pulse_start(32'hDEAD_BEEF, 28'h0123450);
      finish_run(tag, v);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_app_en"}, longint'(app_en), 0);
      check({tag, "_wren"}, longint'(app_wdf_wren), 0);
      check({tag, "_wdf_end"}, longint'(app_wdf_end), 0);
      check({tag, "_busy"}, longint'(busy), 0);
      check({tag, "_done"}, longint'(done), 0);
      check({tag, "_pass"}, longint'(pass), 0);
      check({tag, "_err_cnt"}, longint'(err_cnt), 0);
      check({tag, "_first_err"}, longint'(first_err_addr), 0);
      check({tag, "_app_addr"}, longint'(app_addr), 0);
      check({tag, "_app_cmd"}, longint'(app_cmd), 0);
      check({tag, "_wdf_data_lo"}, longint'(app_wdf_data[63:0]), 0);
      check({tag, "_wdf_data_hi"}, longint'(app_wdf_data[127:64]), 0);
      check({tag, "_side_reqs"}, longint'({app_sr_req, app_ref_req, app_zq_req}), 0);
   endtask

   vec_t vecs [6];

   initial begin
      logic [31:0] tmp;
      int          cw, n;
      vec_t        va, vr;

      rst                 = 1'b1;
      start               = 1'b0;
      seed                = '0;
      base_addr           = '0;
      init_calib_complete = 1'b0;

      vecs[0] = '{32'h0000_0001, 28'h0000000, 100, -1, 16'd0, 28'h0, 1'b1};
      tmp = $urandom;
      vecs[1] = '{$urandom, tmp[27:0], 30, -1, 16'd0, 28'h0, 1'b1};
      vecs[2] = '{32'h0000_0001, 28'h0000000, 100, 5, 16'd1, 28'd40, 1'b0};
      vecs[3] = '{32'h0000_0000, 28'hFFFFFF8, 100, -1, 16'd0, 28'h0, 1'b1};
      tmp = $urandom;
      cw  = int'($urandom_range(W - 1));
      vecs[4] = '{$urandom, tmp[27:0], 30, cw, 16'd1, tmp[27:0] + 28'(cw * STEP), 1'b0};
      vecs[5] = '{$urandom, 28'h0000100, 50, -1, 16'd0, 28'h0, 1'b1};

      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;

      // run held in WAIT_CAL until calibration completes
      prep(vecs[0]);
      pulse_start(vecs[0].seed, vecs[0].base);
      repeat (5) @(negedge clk);
      check("wait_cal_busy", longint'(busy), 1);
      check("wait_cal_app_en", longint'(app_en), 0);
      check("wait_cal_no_cmds", longint'(wr_cmd_n - base_wc), 0);
      init_calib_complete = 1'b1;
      finish_run("wait_cal_run", vecs[0]);

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // calibration lost during WRITE aborts the run
      va = '{32'h0000_0003, 28'h0000000, 100, -1, 16'd0, 28'h0, 1'b1};
      prep(va);
      pulse_start(va.seed, va.base);
      n = 0;
      while ((wr_cmd_n - base_wc) < 6 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_write", longint'(n < 500), 1);
      init_calib_complete = 1'b0;
      @(negedge clk);
      check("abort_done", longint'(done), 1);
      check("abort_pass", longint'(pass), 0);
      check("abort_app_en", longint'(app_en), 0);
      check("abort_wren", longint'(app_wdf_wren), 0);
      check("abort_err_cnt", longint'(err_cnt), 0);
      repeat (3) @(negedge clk);
      init_calib_complete = 1'b1;
      run_vec("after_abort", vecs[0]);

      // reset in READ: everything clears, late beats (one corrupt) are ignored
      vr = '{32'h0000_0001, 28'h0000000, 100, 6, 16'd0, 28'h0, 1'b0};
      prep(vr);
      pulse_start(vr.seed, vr.base);
      n = 0;
      while ((rd_cmd_n - base_rc) < 8 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("rst_reached_read", longint'(n < 500), 1);
      rst = 1'b1;
      @(negedge clk);
      check_idle("rst_mid_run");
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("rst_late_err_cnt", longint'(err_cnt), 0);
      check("rst_late_busy", longint'(busy), 0);
      check("rst_late_done", longint'(done), 0);
      check("rst_late_app_en", longint'(app_en), 0);
      check("rst_late_beats_seen", longint'((rd_beat_n - s_rb) > 0), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
